// File: rtl/tlight_package.sv
// rtl/tlight_package.sv - Shared light and phase types for the traffic light controllers.
package tlight_package;

   // RED, YELLOW and GREEN keep their encodings so the two-way controller is unaffected.
   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2,
      OFF    = 2'd3
   } tlight_control_t;

   typedef enum logic [2:0] {
      ALL_RED = 3'd0,
      READY   = 3'd1,
      GO      = 3'd2,
      STOP    = 3'd3,
      FLASH   = 3'd4
   } tlight_phase_t;

endpackage

// File: rtl/tlight_phase_timer.sv
// rtl/tlight_phase_timer.sv - Loadable down-counter flagging the last cycle of a phase or flash half-period.
module tlight_phase_timer #(
   parameter int                   TIMER_W     = 8,
   parameter logic [TIMER_W-1:0]   RESET_VALUE = '0
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_value,
   output logic               expired
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= RESET_VALUE;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/tlight_multi.sv
// rtl/tlight_multi.sv - N-approach round-robin traffic light controller with night flashing.
// Defining TLIGHT_DEMAND_EN makes the controller skip approaches with no pending request.
module tlight_multi
   import tlight_package::*;
#(
   parameter int NUM_DIRS         = 2,
   parameter int TIMER_W          = 8,
   parameter int ALL_RED_DURATION = 1,
   parameter int YELLOW_DURATION  = 3,
   parameter int GREEN_DURATION   = 15,
   parameter int FLASH_PERIOD     = 1
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        night_mode,
   input  logic [NUM_DIRS-1:0]         request,
   output tlight_control_t             lights [NUM_DIRS],
   output logic [$clog2(NUM_DIRS)-1:0] active_dir,
   output tlight_phase_t               phase
);

   localparam int DW = $clog2(NUM_DIRS);

   if (NUM_DIRS < 2 || NUM_DIRS > 8) begin : g_bad_num_dirs
      $fatal(1, "tlight_multi: NUM_DIRS must be in 2..8");
   end
   if (ALL_RED_DURATION < 1 || YELLOW_DURATION < 1 || GREEN_DURATION < 1 || FLASH_PERIOD < 1) begin : g_bad_min_dur
      $fatal(1, "tlight_multi: every duration must be at least 1");
   end
   if (64'(ALL_RED_DURATION) >= (64'd1 << TIMER_W) || 64'(YELLOW_DURATION) >= (64'd1 << TIMER_W) ||
       64'(GREEN_DURATION) >= (64'd1 << TIMER_W) || 64'(FLASH_PERIOD) >= (64'd1 << TIMER_W)) begin : g_bad_max_dur
      $fatal(1, "tlight_multi: every duration must fit TIMER_W");
   end

   localparam logic [TIMER_W-1:0] AR_LOAD = TIMER_W'(ALL_RED_DURATION - 1);
   localparam logic [TIMER_W-1:0] Y_LOAD  = TIMER_W'(YELLOW_DURATION - 1);
   localparam logic [TIMER_W-1:0] G_LOAD  = TIMER_W'(GREEN_DURATION - 1);
   localparam logic [TIMER_W-1:0] F_LOAD  = TIMER_W'(FLASH_PERIOD - 1);

   logic               expired;
   logic               flash_on;
   logic [TIMER_W-1:0] load_value;
   logic [DW-1:0]      next_dir;

   function automatic logic [DW-1:0] step_dir(input logic [DW-1:0] d, input int j);
      int c;
      c = int'(d) + j;
      if (c >= NUM_DIRS) c = c - NUM_DIRS;
      return DW'(c);
   endfunction

   // Every transition happens on expiry, so the timer reloads with the next phase's length then.
   tlight_phase_timer #(
      .TIMER_W     (TIMER_W),
      .RESET_VALUE (AR_LOAD)
   ) u_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (expired),
      .load_value (load_value),
      .expired    (expired)
   );

   always_comb begin
      load_value = AR_LOAD;
      unique case (phase)
         ALL_RED: load_value = night_mode ? F_LOAD : Y_LOAD;
         READY:   load_value = G_LOAD;
         GO:      load_value = Y_LOAD;
         STOP:    load_value = AR_LOAD;
         FLASH:   load_value = night_mode ? F_LOAD : AR_LOAD;
         default: load_value = AR_LOAD;
      endcase
   end

`ifdef TLIGHT_DEMAND_EN
   logic [NUM_DIRS-1:0] pending;
   logic [NUM_DIRS-1:0] go_mask;
   logic                found;

   // A request coinciding with its own GO entry is absorbed by the clear.
   assign go_mask = (phase == READY && expired) ? (NUM_DIRS'(1) << active_dir) : '0;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pending <= '0;
      end else begin
         pending <= (pending | request) & ~go_mask;
      end
   end

   always_comb begin
      next_dir = step_dir(active_dir, 1);
      found    = 1'b0;
      for (int j = 1; j < NUM_DIRS; j++) begin
         if (!found && pending[step_dir(active_dir, j)]) begin
            next_dir = step_dir(active_dir, j);
            found    = 1'b1;
         end
      end
      if (!found && pending[active_dir]) next_dir = active_dir;
   end
`else
   logic unused_request;
   assign unused_request = ^request;

   always_comb begin
      next_dir = step_dir(active_dir, 1);
   end
`endif

   // Night mode is only honoured at ALL_RED exit and at flash half-period boundaries.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         phase      <= ALL_RED;
         active_dir <= '0;
         flash_on   <= 1'b1;
      end else if (expired) begin
         unique case (phase)
            ALL_RED: begin
               if (night_mode) begin
                  phase    <= FLASH;
                  flash_on <= 1'b1;
               end else begin
                  phase <= READY;
               end
            end
            READY: phase <= GO;
            GO:    phase <= STOP;
            STOP: begin
               phase      <= ALL_RED;
               active_dir <= next_dir;
            end
            FLASH: begin
               if (night_mode) flash_on <= ~flash_on;
               else            phase    <= ALL_RED;
            end
            default: phase <= ALL_RED;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_DIRS; i++) begin
         lights[i] = RED;
         if (phase == FLASH) begin
            lights[i] = flash_on ? YELLOW : OFF;
         end else if (DW'(i) == active_dir) begin
            if (phase == READY || phase == STOP) lights[i] = YELLOW;
            else if (phase == GO)                lights[i] = GREEN;
         end
      end
   end

endmodule

// File: tb/tb_tlight_multi.sv
// tb/tb_tlight_multi.sv - Bench for tlight_multi: two configurations against a phase-list reference model.
module tb_tlight_multi;
   import tlight_package::*;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic            reset_n;
   logic            night_mode;
   logic [2:0]      req_a;
   logic [3:0]      req_b;
   tlight_control_t lights_a [3];
   tlight_control_t lights_b [4];
   logic [1:0]      dir_a, dir_b;
   tlight_phase_t   phase_a, phase_b;

   tlight_multi #(.NUM_DIRS(3), .TIMER_W(8), .ALL_RED_DURATION(1), .YELLOW_DURATION(2),
                  .GREEN_DURATION(4), .FLASH_PERIOD(2)) u_dut_a (
      .clock(clock), .reset_n(reset_n), .night_mode(night_mode), .request(req_a),
      .lights(lights_a), .active_dir(dir_a), .phase(phase_a));

   tlight_multi #(.NUM_DIRS(4), .TIMER_W(8), .ALL_RED_DURATION(1), .YELLOW_DURATION(1),
                  .GREEN_DURATION(1), .FLASH_PERIOD(1)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .night_mode(night_mode), .request(req_b),
      .lights(lights_b), .active_dir(dir_b), .phase(phase_b));

`ifdef TLIGHT_DEMAND_EN
   localparam bit DEMAND = 1'b1;
`else
   localparam bit DEMAND = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int nd [2] = '{3, 4};
   int ar [2] = '{1, 1};
   int yd [2] = '{2, 1};
   int gd [2] = '{4, 1};
   int fp [2] = '{2, 1};

   tlight_phase_t m_phase [2];
   int            m_elapsed [2];
   int            m_dir [2];
   bit            m_yel [2];
   bit [7:0]      m_pend [2];

   logic [20:0] obs [2];
   always_comb begin
      obs[0] = '0;
      obs[1] = '0;
      obs[0][20:18] = phase_a;
      obs[0][17:16] = dir_a;
      obs[1][20:18] = phase_b;
      obs[1][17:16] = dir_b;
      for (int i = 0; i < 3; i++) obs[0][2*i +: 2] = lights_a[i];
      for (int i = 0; i < 4; i++) obs[1][2*i +: 2] = lights_b[i];
   end

   function automatic int dur(input int k, input tlight_phase_t p);
      case (p)
         ALL_RED:     return ar[k];
         READY, STOP: return yd[k];
         GO:          return gd[k];
         default:     return fp[k];
      endcase
   endfunction

   function automatic int pick_next(input int k, input bit [7:0] pend);
      int d = m_dir[k];
      if (DEMAND) begin
         for (int j = 1; j < nd[k]; j++)
            if (pend[(d + j) % nd[k]]) return (d + j) % nd[k];
         if (pend[d]) return d;
      end
      return (d + 1) % nd[k];
   endfunction

   function automatic logic [20:0] exp_vec(input int k);
      logic [20:0]     v = '0;
      tlight_control_t l;
      v[20:18] = m_phase[k];
      v[17:16] = 2'(m_dir[k]);
      for (int i = 0; i < nd[k]; i++) begin
         l = RED;
         if (m_phase[k] == FLASH) l = m_yel[k] ? YELLOW : OFF;
         else if (i == m_dir[k]) begin
            if (m_phase[k] == GO)                           l = GREEN;
            else if (m_phase[k] == READY || m_phase[k] == STOP) l = YELLOW;
         end
         v[2*i +: 2] = l;
      end
      return v;
   endfunction

   task automatic model_step(input int k, input bit rst, input bit night, input bit [7:0] req);
      bit [7:0] old;
      bit       go_entry = 1'b0;
      if (!rst) begin
         m_phase[k] = ALL_RED; m_elapsed[k] = 0; m_dir[k] = 0; m_yel[k] = 1'b1; m_pend[k] = '0;
         return;
      end
      old = m_pend[k];
      m_elapsed[k]++;
      if (m_elapsed[k] == dur(k, m_phase[k])) begin
         m_elapsed[k] = 0;
         case (m_phase[k])
            ALL_RED: if (night) begin m_phase[k] = FLASH; m_yel[k] = 1'b1; end
                     else m_phase[k] = READY;
            READY:   begin m_phase[k] = GO; go_entry = 1'b1; end
            GO:      m_phase[k] = STOP;
            STOP:    begin m_phase[k] = ALL_RED; m_dir[k] = pick_next(k, old); end
            default: if (night) m_yel[k] = ~m_yel[k];
                     else m_phase[k] = ALL_RED;
         endcase
      end
      if (DEMAND) begin
         m_pend[k] = old | req;
         if (go_entry) m_pend[k][m_dir[k]] = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step(0, reset_n, night_mode, {5'b0, req_a});
      model_step(1, reset_n, night_mode, {4'b0, req_b});
      cyc++;
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; night_mode = 1'b0; req_a = '0; req_b = '0;
      repeat (3) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_vec(k)) begin
               bad++; $display("FAIL reset_model inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
            end
         end
      end
      total++;
      if (phase_a !== ALL_RED || dir_a !== 2'd0 || lights_a[1] !== RED) begin
         bad++; $display("FAIL reset_state: got phase=%0d dir=%0d l1=%0d expected phase=0 dir=0 l1=0", phase_a, dir_a, lights_a[1]);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_round_robin();
      int          entries [$];
      int          dirs [$];
      int          entries_b [$];
      tlight_phase_t prev_a = phase_a, prev_b = phase_b;
      for (int n = 0; n < 80; n++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_vec(k)) begin
               bad++; $display("FAIL rr_model inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
            end
         end
         if (phase_a == READY && prev_a != READY) begin
            dirs.push_back(int'(dir_a));
            if (dir_a == 2'd0) entries.push_back(cyc);
         end
         if (phase_b == READY && prev_b != READY && dir_b == 2'd0) entries_b.push_back(cyc);
         prev_a = phase_a; prev_b = phase_b;
      end
      total++;
      if (entries.size() < 2 || entries[1] - entries[0] != 27) begin
         bad++; $display("FAIL rr_period_a: got entries=%0d span=%0d expected span=27", entries.size(),
                         entries.size() >= 2 ? entries[1] - entries[0] : -1);
      end
      total++;
      if (entries_b.size() < 2 || entries_b[1] - entries_b[0] != 16) begin
         bad++; $display("FAIL rr_period_b: got entries=%0d span=%0d expected span=16", entries_b.size(),
                         entries_b.size() >= 2 ? entries_b[1] - entries_b[0] : -1);
      end
      total++;
      if (dirs.size() < 4 || dirs[0] != 0 || dirs[1] != 1 || dirs[2] != 2 || dirs[3] != 0) begin
         bad++; $display("FAIL rr_dir_seq: got %p expected 0,1,2,0", dirs);
      end
   endtask

   task automatic test_night();
      int            n;
      tlight_phase_t before_flash = ALL_RED, prev;
      n = 0;
      while (!(phase_a == GO && dir_a == 2'd1) && n < 100) begin tick(); n++; end
      total++;
      if (n >= 100) begin bad++; $display("FAIL night_wait_go1: got timeout expected GO of approach 1"); end
      night_mode = 1'b1;
      n = 0;
      prev = phase_a;
      while (phase_a != FLASH && n < 40) begin
         prev = phase_a;
         tick(); n++;
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_vec(k)) begin
               bad++; $display("FAIL night_entry_model inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
            end
         end
         if (phase_a == FLASH) before_flash = prev;
      end
      total++;
      if (phase_a !== FLASH || before_flash !== ALL_RED) begin
         bad++; $display("FAIL night_flash_entry: got phase=%0d prev=%0d expected phase=4 prev=0", phase_a, before_flash);
      end
      repeat (7 + $urandom_range(0, 3)) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_vec(k)) begin
               bad++; $display("FAIL flash_model inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
            end
         end
      end
      night_mode = 1'b0;
      n = 0;
      while (phase_a != READY && n < 20) begin
         tick(); n++;
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_vec(k)) begin
               bad++; $display("FAIL flash_exit_model inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
            end
         end
      end
      total++;
      if (phase_a !== READY || dir_a !== 2'd2 || lights_a[2] !== YELLOW) begin
         bad++; $display("FAIL flash_exit_ready: got phase=%0d dir=%0d expected phase=1 dir=2", phase_a, dir_a);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      while (!(phase_a == GO && dir_a == 2'd2) && n < 100) begin tick(); n++; end
      total++;
      if (n >= 100) begin bad++; $display("FAIL rst_wait_go2: got timeout expected GO of approach 2"); end
      reset_n = 1'b0;
      repeat (3) begin
         tick();
         total++;
         if (phase_a !== ALL_RED || dir_a !== 2'd0 || lights_a[2] !== RED || lights_a[0] !== RED) begin
            bad++; $display("FAIL rst_mid_state: got phase=%0d dir=%0d l2=%0d expected phase=0 dir=0 l2=0", phase_a, dir_a, lights_a[2]);
         end
         total++;
         if (obs[1] !== exp_vec(1)) begin
            bad++; $display("FAIL rst_mid_model_b cyc%0d: got %h expected %h", cyc, obs[1], exp_vec(1));
         end
      end
      reset_n = 1'b1;
   endtask

   task automatic test_demand();
      int            seq [$];
      int            n = 0;
      tlight_phase_t prev;
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      while (!(phase_b == GO && dir_b == 2'd0) && n < 40) begin tick(); n++; end
      total++;
      if (n >= 40) begin bad++; $display("FAIL demand_wait_go0: got timeout expected GO of approach 0"); end
      req_b = 4'b0100;
      prev = phase_b;
      tick();
      req_b = '0;
      n = 0;
      while (seq.size() < 3 && n < 60) begin
         prev = phase_b;
         tick(); n++;
         total++;
         if (obs[1] !== exp_vec(1)) begin
            bad++; $display("FAIL demand_model cyc%0d: got %h expected %h", cyc, obs[1], exp_vec(1));
         end
         if (phase_b == READY && prev != READY) seq.push_back(int'(dir_b));
      end
      total++;
      if (seq.size() < 3 || seq[0] != (DEMAND ? 2 : 1) || seq[1] != (DEMAND ? 3 : 2) || seq[2] != (DEMAND ? 0 : 3)) begin
         bad++; $display("FAIL demand_seq: got %p expected %0d,%0d,%0d", seq,
                         DEMAND ? 2 : 1, DEMAND ? 3 : 2, DEMAND ? 0 : 3);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 39) == 0) night_mode = ~night_mode;
         reset_n = ($urandom_range(0, 199) != 0);
         for (int i = 0; i < 3; i++) req_a[i] = ($urandom_range(0, 7) == 0);
         for (int i = 0; i < 4; i++) req_b[i] = ($urandom_range(0, 7) == 0);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_vec(k)) begin
               bad++; $display("FAIL random_model inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
            end
         end
      end
      reset_n = 1'b1; night_mode = 1'b0; req_a = '0; req_b = '0;
   endtask

   initial begin
      reset_n = 1'b0; night_mode = 1'b0; req_a = '0; req_b = '0;
      @(negedge clock);
      test_reset();
      test_round_robin();
      test_night();
      test_reset_mid();
      test_demand();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
